// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide unit: 32-step shift-add multiply or restoring
// divide, then a one-cycle register file write-back.
module mdu_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] regA,
   input  logic [31:0] regB,
   input  logic [4:0]  rd_addr,
   output logic        busy,
   output logic [31:0] regC,
   output logic [4:0]  regC_addr,
   output logic        wen
);

   typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

   state_t      state_reg, state_next;
   logic [5:0]  cnt_reg;
   logic [1:0]  op_reg;
   logic [31:0] opnd_reg;
   logic [63:0] acc_reg;
   logic [63:0] acc_step;
   logic [4:0]  rd_reg;
   logic [31:0] regc_reg;
   logic [4:0]  regc_addr_reg;
   logic        wen_reg;

   logic [32:0] mul_sum;
   logic [32:0] rem_sh;
   logic        div_ge;
   logic [31:0] div_trial;
   logic        last_iter;
   logic [31:0] result;

   // acc holds {hi, lo} of the product, or {remainder, quotient} while dividing
   assign mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, opnd_reg};
   assign rem_sh    = acc_reg[63:31];
   assign div_ge    = (rem_sh >= {1'b0, opnd_reg});
   assign div_trial = rem_sh[31:0] - opnd_reg;
   assign last_iter = (state_reg == CALC) && (cnt_reg == 6'd31);
   assign result    = op_reg[0] ? acc_step[63:32] : acc_step[31:0];

   always_comb begin
      acc_step = acc_reg;
      if (!op_reg[1]) begin
         if (acc_reg[0])
            acc_step = {mul_sum, acc_reg[31:1]};
         else
            acc_step = {1'b0, acc_reg[63:1]};
      end else begin
         // the trial difference fits in 32 bits whenever it does not borrow
         if (div_ge)
            acc_step = {div_trial, acc_reg[30:0], 1'b1};
         else
            acc_step = {rem_sh[31:0], acc_reg[30:0], 1'b0};
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (cnt_reg == 6'd31) state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg       <= 6'd0;
         op_reg        <= 2'd0;
         opnd_reg      <= 32'd0;
         acc_reg       <= 64'd0;
         rd_reg        <= 5'd0;
         regc_reg      <= 32'd0;
         regc_addr_reg <= 5'd0;
         wen_reg       <= 1'b0;
      end else begin
         wen_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  op_reg  <= op;
                  rd_reg  <= rd_addr;
                  cnt_reg <= 6'd0;
                  if (op[1]) begin
                     opnd_reg <= regB;
                     acc_reg  <= {32'd0, regA};
                  end else begin
                     opnd_reg <= regA;
                     acc_reg  <= {32'd0, regB};
                  end
               end
            end
            CALC: begin
               acc_reg <= acc_step;
               cnt_reg <= cnt_reg + 6'd1;
               if (last_iter) begin
                  regc_reg      <= result;
                  regc_addr_reg <= rd_reg;
                  wen_reg       <= (rd_reg != 5'd0);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_reg != IDLE);
   assign regC      = regc_reg;
   assign regC_addr = regc_addr_reg;
   assign wen       = wen_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: per-cycle comparison against a countdown/arithmetic
// reference model, directed literal cases, reset abort and randomized traffic.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] regA = 32'd0;
   logic [31:0] regB = 32'd0;
   logic [4:0]  rd_addr = 5'd0;
   logic        busy;
   logic [31:0] regC;
   logic [4:0]  regC_addr;
   logic        wen;

   int checks = 0;
   int errors = 0;

   mdu_iter dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .regA(regA), .regB(regB),
      .rd_addr(rd_addr), .busy(busy), .regC(regC), .regC_addr(regC_addr), .wen(wen)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_fn(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (o)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // Reference model: an accepted op occupies 33 cycles; its result appears in the last one.
   int          m_cd = 0;
   logic [31:0] m_res = 32'd0;
   logic [4:0]  m_rd = 5'd0;
   logic [31:0] m_c = 32'd0;
   logic [4:0]  m_addr = 5'd0;
   logic        m_wen = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cd   <= 0;
         m_c    <= 32'd0;
         m_addr <= 5'd0;
         m_wen  <= 1'b0;
      end else begin
         m_wen <= 1'b0;
         if (m_cd == 0) begin
            if (start) begin
               m_cd  <= 33;
               m_res <= ref_fn(op, regA, regB);
               m_rd  <= rd_addr;
            end
         end else begin
            m_cd <= m_cd - 1;
            if (m_cd == 2) begin
               m_c    <= m_res;
               m_addr <= m_rd;
               m_wen  <= (m_rd != 5'd0);
            end
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (busy !== (m_cd != 0) || wen !== m_wen || regC !== m_c || regC_addr !== m_addr) begin
         errors++;
         $display("FAIL cycle_compare t=%0t: busy=%b wen=%b regC=%h addr=%0d, required busy=%b wen=%b regC=%h addr=%0d",
                  $time, busy, wen, regC, regC_addr, (m_cd != 0), m_wen, m_c, m_addr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after 100 cycles, required 0", busy);
   endtask

   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit flood);
      int          nwen, nbusy, lat;
      logic [31:0] got_c;
      logic [4:0]  got_a;
      wait_idle();
      op = o; regA = a; regB = b; rd_addr = rd; start = 1'b1;
      nwen = 0; nbusy = 0; lat = 0; got_c = 32'd0; got_a = 5'd0;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         if (!flood) start = 1'b0;
         else begin
            op = 2'($urandom); regA = $urandom; regB = $urandom; rd_addr = 5'($urandom);
         end
         if (busy) nbusy++;
         if (wen) begin nwen++; lat = k; end
         if (k == 33) begin got_c = regC; got_a = regC_addr; end
      end
      $display("op=%0d a=%h b=%h rd=%0d flood=%0d -> regC=%h addr=%0d wen_pulses=%0d",
               o, a, b, rd, flood, got_c, got_a, nwen);
      chk("busy_cycles", 32'(nbusy), 32'd33);
      chk("wen_pulses", 32'(nwen), (rd != 5'd0) ? 32'd1 : 32'd0);
      if (rd != 5'd0) chk("wen_latency", 32'(lat), 32'd33);
      chk("result", got_c, exp);
      chk("result_addr", {27'd0, got_a}, {27'd0, rd});
      if (flood) begin
         @(negedge clk);
         chk("reaccept_busy", {31'd0, busy}, 32'd1);
         start = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  o;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          nwen, nbusy;

      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_wen", {31'd0, wen}, 32'd0);
      chk("reset_regC", regC, 32'd0);
      chk("reset_addr", {27'd0, regC_addr}, 32'd0);
      rst = 1'b0;

      do_op(2'd0, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0);
      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0);
      do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001, 1'b0);
      do_op(2'd2, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0);
      do_op(2'd3, 32'd100, 32'd7, 5'd4, 32'd2, 1'b0);
      do_op(2'd2, 32'h8000_0000, 32'd1, 5'd6, 32'h8000_0000, 1'b0);
      do_op(2'd2, 32'h1234_5678, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b0);
      do_op(2'd3, 32'h1234_5678, 32'd0, 5'd8, 32'h1234_5678, 1'b0);
      do_op(2'd0, 32'd3, 32'd4, 5'd9, 32'd12, 1'b1);
      do_op(2'd2, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0);

      // abort an operation mid-flight with an asynchronous reset
      wait_idle();
      op = 2'd0; regA = 32'd3; regB = 32'd5; rd_addr = 5'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_wen", {31'd0, wen}, 32'd0);
      chk("abort_regC", regC, 32'd0);
      chk("abort_addr", {27'd0, regC_addr}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      nwen = 0; nbusy = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (wen) nwen++;
         if (busy) nbusy++;
      end
      chk("abort_no_wen", 32'(nwen), 32'd0);
      chk("abort_no_busy", 32'(nbusy), 32'd0);

      for (int n = 0; n < 30; n++) begin
         o = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         rd = 5'($urandom_range(0, 31));
         do_op(o, a, b, rd, ref_fn(o, a, b), ($urandom_range(0, 4) == 0));
      end

      wait_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
